// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Purpose  : MEM/WB buffer that pre-computes register-file write data at accept
//            time and retires one entry per granted cycle, in order.
//            Optional head-entry bypass enabled by macro WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic [XLEN-1:0] in_mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_gnt,
    output logic [XLEN-1:0] wb_pc,
    output logic [31:0]     retire_cnt,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN-1:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Entry storage; reset so that held head outputs are never X.
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic            we_q   [DEPTH];
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [XLEN-1:0] wb_pc_q,  wb_pc_d;
    logic [31:0]     retire_cnt_q, retire_cnt_d;
    logic [4:0]      last_rd_q,   last_rd_d;
    logic [XLEN-1:0] last_data_q, last_data_d;

    logic            w_nonempty;
    logic            w_retire;
    logic            w_accept;
    logic            w_wr;
    logic            w_we;
    logic [XLEN-1:0] w_wdata;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic            w_unused;

    assign w_unused   = ^{in_ir[31:15]};
    assign w_nonempty = (count_q != '0);
    assign w_retire   = w_nonempty && rf_gnt;
    assign in_ready   = (count_q < CW'(DEPTH)) || w_retire;
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_wr    = 1'b0;
        w_wdata = '0;
        case (in_ir[6:0])
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                w_wr    = 1'b1;
                w_wdata = in_alu_out;
            end
            OP_JAL, OP_JALR: begin
                w_wr    = 1'b1;
                w_wdata = in_pc + XLEN'(4);
            end
            OP_LOAD: begin
                w_wr    = 1'b1;
                w_wdata = load_extract(in_ir[14:12], in_alu_out[1:0], in_mem_rdata);
            end
            default: begin
                w_wr    = 1'b0;
                w_wdata = '0;
            end
        endcase
        w_we = w_wr && (in_ir[11:7] != 5'd0);
    end

    // When empty, expose the most recently retired entry rather than stale slots.
    assign w_head_rd   = w_nonempty ? rd_q[rd_ptr_q]   : last_rd_q;
    assign w_head_data = w_nonempty ? data_q[rd_ptr_q] : last_data_q;

    assign rf_we      = we_q[rd_ptr_q] && w_retire;
    assign rf_waddr   = w_head_rd;
    assign rf_wdata   = w_head_data;
    assign wb_pc      = wb_pc_q;
    assign retire_cnt = retire_cnt_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid = w_nonempty && we_q[rd_ptr_q];
    assign fwd_rd    = w_head_rd;
    assign fwd_data  = w_head_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wb_pc_d      = wb_pc_q;
        retire_cnt_d = retire_cnt_q;
        last_rd_d    = last_rd_q;
        last_data_d  = last_data_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_retire) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            wb_pc_d      = pc_q[rd_ptr_q];
            retire_cnt_d = retire_cnt_q + 32'd1;
            last_rd_d    = rd_q[rd_ptr_q];
            last_data_d  = data_q[rd_ptr_q];
        end
        case ({w_accept, w_retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wb_pc_q      <= '0;
            retire_cnt_q <= '0;
            last_rd_q    <= '0;
            last_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                we_q[i]   <= 1'b0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wb_pc_q      <= wb_pc_d;
            retire_cnt_q <= retire_cnt_d;
            last_rd_q    <= last_rd_d;
            last_data_q  <= last_data_d;
            if (w_accept) begin
                pc_q[wr_ptr_q]   <= in_pc;
                we_q[wr_ptr_q]   <= w_we;
                rd_q[wr_ptr_q]   <= in_ir[11:7];
                data_q[wr_ptr_q] <= w_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Purpose  : Directed self-checking bench for writeback_unit (XLEN=32, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_ir;
    logic [31:0] in_alu_out;
    logic [31:0] in_mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_gnt;
    logic [31:0] wb_pc;
    logic [31:0] retire_cnt;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int errors;
    int checks;
    logic [31:0] exp_cnt;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    writeback_unit #(.XLEN(32), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_ir        (in_ir),
        .in_alu_out   (in_alu_out),
        .in_mem_rdata (in_mem_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_gnt       (rf_gnt),
        .wb_pc        (wb_pc),
        .retire_cnt   (retire_cnt),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3);
        return {17'd0, f3, rd, op};
    endfunction

    // Offer one entry for a single clock (caller guarantees in_ready is high).
    task automatic push(input logic [31:0] pc, input logic [31:0] ir,
                        input logic [31:0] alu, input logic [31:0] mem);
        in_pc = pc; in_ir = ir; in_alu_out = alu; in_mem_rdata = mem;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic retire_one();
        rf_gnt = 1'b1;
        @(posedge clk); #1;
        rf_gnt = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; rf_gnt = 1'b0;
        in_pc = '0; in_ir = '0; in_alu_out = '0; in_mem_rdata = '0;
        exp_cnt = '0;
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire_cnt got=%h exp=0", retire_cnt); end
        checks++; if (wb_pc !== 32'd0) begin errors++; $display("FAIL reset_wb_pc got=%h exp=0", wb_pc); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
        checks++; if (rf_wdata !== 32'd0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_head got=%h/%0d exp=0/0", rf_wdata, rf_waddr); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_alu();
        push(32'h0000_0100, mk_ir(OP_R, 5'd5, 3'b000), 32'h0000_00AA, 32'h0);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_no_gnt got=%b exp=0", rf_we); end
        rf_gnt = 1'b1; #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_rf_we got=%b exp=1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_rf_waddr got=%0d exp=5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0000_00AA) begin errors++; $display("FAIL alu_rf_wdata got=%h exp=000000aa", rf_wdata); end
        @(posedge clk); #1;
        rf_gnt = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL alu_retire_cnt got=%0d exp=1", retire_cnt); end
        checks++; if (wb_pc !== 32'h0000_0100) begin errors++; $display("FAIL alu_wb_pc got=%h exp=00000100", wb_pc); end
    endtask

    task automatic test_load();
        push(32'h200, mk_ir(OP_LOAD, 5'd3, 3'b000), 32'h0000_0001, 32'h1234_80FF);
        checks++; if (rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_lb got=%h exp=ffffff80", rf_wdata); end
        retire_one();
        push(32'h204, mk_ir(OP_LOAD, 5'd3, 3'b100), 32'h0000_0001, 32'h1234_80FF);
        checks++; if (rf_wdata !== 32'h0000_0080) begin errors++; $display("FAIL load_lbu got=%h exp=00000080", rf_wdata); end
        retire_one();
        push(32'h208, mk_ir(OP_LOAD, 5'd3, 3'b001), 32'h0000_0002, 32'h1234_80FF);
        checks++; if (rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL load_lh got=%h exp=00001234", rf_wdata); end
        retire_one();
        push(32'h20C, mk_ir(OP_LOAD, 5'd3, 3'b001), 32'h0000_0000, 32'h1234_80FF);
        checks++; if (rf_wdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL load_lh0 got=%h exp=ffff80ff", rf_wdata); end
        retire_one();
        push(32'h210, mk_ir(OP_LOAD, 5'd3, 3'b010), 32'h0000_0000, 32'h1234_80FF);
        checks++; if (rf_wdata !== 32'h1234_80FF) begin errors++; $display("FAIL load_lw got=%h exp=123480ff", rf_wdata); end
        retire_one();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL load_retire_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); end
    endtask

    task automatic test_jal_x0();
        push(32'h0000_1000, mk_ir(OP_JAL, 5'd1, 3'b000), 32'hDEAD_BEEF, 32'h0);
        checks++; if (rf_wdata !== 32'h0000_1004) begin errors++; $display("FAIL jal_wdata got=%h exp=00001004", rf_wdata); end
        retire_one();
        checks++; if (wb_pc !== 32'h0000_1000) begin errors++; $display("FAIL jal_wb_pc got=%h exp=00001000", wb_pc); end
        push(32'h0000_1004, mk_ir(OP_I, 5'd0, 3'b000), 32'h0000_0077, 32'h0);
        rf_gnt = 1'b1; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL addi_x0_we got=%b exp=0", rf_we); end
        @(posedge clk); #1;
        rf_gnt = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL addi_x0_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); end
        checks++; if (wb_pc !== 32'h0000_1004) begin errors++; $display("FAIL addi_x0_wb_pc got=%h exp=00001004", wb_pc); end
        push(32'h0000_1008, mk_ir(OP_STORE, 5'd9, 3'b010), 32'h0000_0010, 32'h0);
        rf_gnt = 1'b1; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL store_we got=%b exp=0", rf_we); end
        @(posedge clk); #1;
        rf_gnt = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_back_to_back();
        rf_gnt = 1'b0;
        in_valid = 1'b1; in_ir = mk_ir(OP_I, 5'd10, 3'b000); in_alu_out = 32'h10; in_pc = 32'h300;
        @(posedge clk); #1;
        in_ir = mk_ir(OP_I, 5'd11, 3'b000); in_alu_out = 32'h11; in_pc = 32'h304;
        @(posedge clk); #1;
        in_ir = mk_ir(OP_I, 5'd12, 3'b000); in_alu_out = 32'h12; in_pc = 32'h308;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        rf_gnt = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_retire_ready got=%b exp=1", in_ready); end
        checks++; if (rf_waddr !== 5'd10) begin errors++; $display("FAIL order_head0 got=%0d exp=10", rf_waddr); end
        @(posedge clk); #1;
        in_valid = 1'b0; rf_gnt = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL still_full got=%b exp=0", in_ready); end
        checks++; if (wb_pc !== 32'h300) begin errors++; $display("FAIL order_wb_pc0 got=%h exp=00000300", wb_pc); end
        checks++; if (rf_waddr !== 5'd11) begin errors++; $display("FAIL order_head1 got=%0d exp=11", rf_waddr); end
        rf_gnt = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (rf_waddr !== 5'd12 || rf_wdata !== 32'h12) begin errors++; $display("FAIL order_head2 got=%0d/%h exp=12/00000012", rf_waddr, rf_wdata); end
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL empty_we got=%b exp=0", rf_we); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_retire_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); end
        checks++; if (rf_waddr !== 5'd12 || rf_wdata !== 32'h12) begin errors++; $display("FAIL empty_hold got=%0d/%h exp=12/00000012", rf_waddr, rf_wdata); end
        checks++; if (wb_pc !== 32'h308) begin errors++; $display("FAIL b2b_wb_pc got=%h exp=00000308", wb_pc); end
        rf_gnt = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        push(32'h400, mk_ir(OP_I, 5'd20, 3'b000), 32'h20, 32'h0);
        push(32'h404, mk_ir(OP_I, 5'd21, 3'b000), 32'h21, 32'h0);
        rf_gnt = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got=%b exp=0", rf_we); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_cnt got=%0d exp=0", retire_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        checks++; if (wb_pc !== 32'd0) begin errors++; $display("FAIL rst_mid_wb_pc got=%h exp=0", wb_pc); end
        exp_cnt = '0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0 || retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_discard got=%b/%0d exp=0/0", rf_we, retire_cnt); end
        rf_gnt = 1'b0;
    endtask

    task automatic test_bypass();
        push(32'h500, mk_ir(OP_I, 5'd7, 3'b000), 32'h55, 32'h0);
`ifdef WB_BYPASS_EN
        checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got=%b exp=1", fwd_valid); end
        checks++; if (fwd_rd !== 5'd7) begin errors++; $display("FAIL fwd_rd got=%0d exp=7", fwd_rd); end
        checks++; if (fwd_data !== 32'h55) begin errors++; $display("FAIL fwd_data got=%h exp=00000055", fwd_data); end
`else
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_valid_off got=%b exp=0", fwd_valid); end
        checks++; if (fwd_rd !== 5'd0 || fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_off got=%0d/%h exp=0/0", fwd_rd, fwd_data); end
`endif
        retire_one();
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_empty got=%b exp=0", fwd_valid); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL bypass_cnt got=%0d exp=%0d", retire_cnt, exp_cnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_alu();
        test_load();
        test_jal_x0();
        test_back_to_back();
        test_reset_mid_stall();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
